// File: rtl/nf10_filter_egress_stats.sv
// nf10_filter_egress_stats: skid-buffered AXI4-Stream stage that counts packets, bytes and
// per-source-port packets as downstream accepts them.
module nf10_filter_egress_stats #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic                            stats_clear,
  output logic [C_CNT_WIDTH-1:0]          pkt_count,
  output logic [C_CNT_WIDTH-1:0]          byte_count,
  output logic [4*C_CNT_WIDTH-1:0]        port_pkt_count
);
  localparam int W = C_AXIS_DATA_WIDTH + C_AXIS_DATA_WIDTH/8 + C_AXIS_TUSER_WIDTH + 1;
  typedef enum logic {SOP, MID} state_t;
  logic [W-1:0] s_beat, main_q, skid_q;
  logic main_valid, skid_valid, m_fire, s_fire, load_main, sop_ev, eop_ev;
  logic [C_CNT_WIDTH-1:0] port_cnt [4];
  state_t state, state_nxt;
  assign s_beat = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = main_q;
  assign m_axis_tvalid = main_valid;
  assign s_axis_tready = ~skid_valid;
  assign m_fire = main_valid & m_axis_tready;
  assign s_fire = s_axis_tvalid & ~skid_valid;
  assign load_main = ~main_valid | m_fire;
  // skid can only be occupied while main is stalled, so it always refills main first
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_valid <= load_main ? (skid_valid | s_fire) : main_valid;
      main_q     <= (load_main & (skid_valid | s_fire)) ? (skid_valid ? skid_q : s_beat) : main_q;
      skid_valid <= load_main ? 1'b0 : (skid_valid | s_fire);
      skid_q     <= (~load_main & s_fire) ? s_beat : skid_q;
    end
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) state <= SOP;
    else              state <= state_nxt;
  always_comb state_nxt = ~m_fire ? state : (m_axis_tlast ? SOP : MID);
  always_comb begin
    sop_ev = m_fire & (state == SOP);
    eop_ev = m_fire & m_axis_tlast;
  end
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      pkt_count  <= '0;
      byte_count <= '0;
      for (int i = 0; i < 4; i++) port_cnt[i] <= '0;
    end else begin
      pkt_count  <= stats_clear ? '0 : pkt_count + C_CNT_WIDTH'(eop_ev);
      byte_count <= stats_clear ? '0 : byte_count + (sop_ev ? C_CNT_WIDTH'(m_axis_tuser[15:0]) : '0);
      for (int i = 0; i < 4; i++)
        port_cnt[i] <= stats_clear ? '0 : port_cnt[i] + C_CNT_WIDTH'(sop_ev & m_axis_tuser[16+2*i]);
    end
  for (genvar i = 0; i < 4; i++) begin : g_port
    assign port_pkt_count[i*C_CNT_WIDTH +: C_CNT_WIDTH] = port_cnt[i];
  end
endmodule

// File: tb/tb_nf10_filter_egress_stats.sv
// tb_nf10_filter_egress_stats: random and directed traffic checked against a beat queue and
// packet-level counter model.
module tb_nf10_filter_egress_stats;
  localparam int DW = 256, UW = 128, CW = 32;
  typedef struct packed {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] s;
    logic [UW-1:0]   u;
    logic            l;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [DW/8-1:0] s_axis_tstrb, m_axis_tstrb;
  logic [UW-1:0] s_axis_tuser, m_axis_tuser;
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready, stats_clear;
  logic [CW-1:0] pkt_count, byte_count;
  logic [4*CW-1:0] port_pkt_count;
  always #5 clk = ~clk;
  nf10_filter_egress_stats dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .stats_clear(stats_clear), .pkt_count(pkt_count), .byte_count(byte_count),
    .port_pkt_count(port_pkt_count)
  );
  int n_cmp = 0, n_bad = 0, n_in = 0;
  beat_t q[$];
  beat_t cur;
  logic [CW-1:0] e_pkt, e_byte;
  logic [CW-1:0] e_port [4];
  bit in_pkt, pending, prev_sready, prev_mready, g_rand;
  int beats_left, g_nb;
  logic [15:0] g_len;
  logic [7:0] g_port;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_counters(input string pfx);
    chk({pfx, "_pkt"}, pkt_count, e_pkt);
    chk({pfx, "_byte"}, byte_count, e_byte);
    for (int i = 0; i < 4; i++) chk({pfx, "_port"}, port_pkt_count[i*CW +: CW], e_port[i]);
  endtask
  task automatic model_clear();
    e_pkt = '0;
    e_byte = '0;
    for (int i = 0; i < 4; i++) e_port[i] = '0;
  endtask
  task automatic new_beat();
    bit start;
    start = (beats_left == 0);
    if (start) beats_left = g_rand ? int'($urandom_range(1, 4)) : g_nb;
    for (int k = 0; k < DW/32; k++) cur.d[k*32 +: 32] = $urandom;
    cur.s = $urandom;
    for (int k = 0; k < UW/32; k++) cur.u[k*32 +: 32] = $urandom;
    if (start) begin
      cur.u[15:0]  = g_rand ? 16'($urandom) : g_len;
      cur.u[23:16] = g_rand ? 8'($urandom) : g_port;
    end
    cur.l = (beats_left == 1);
    beats_left--;
  endtask
  // one clock: check state seen so far, drive new inputs, then account for this cycle's handshakes
  task automatic step(input bit sv, input bit mr, input bit clr);
    beat_t exp;
    @(negedge clk);
    chk_counters("cnt");
    chk("m_valid", m_axis_tvalid, q.size() != 0);
    chk("s_ready", s_axis_tready, q.size() < 2);
    if (!prev_sready && prev_mready) chk("s_ready_recover", s_axis_tready, 1'b1);
    prev_sready = s_axis_tready;
    prev_mready = mr;
    if (!pending && sv) begin
      new_beat();
      pending = 1'b1;
    end
    s_axis_tvalid = pending;
    {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast} = cur;
    m_axis_tready = mr;
    stats_clear = clr;
    #1;
    if (m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
      else begin
        exp = q.pop_front();
        chk("beat", {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast}, exp);
        if (!in_pkt) begin
          e_byte += CW'(exp.u[15:0]);
          for (int i = 0; i < 4; i++) e_port[i] += CW'(exp.u[16+2*i]);
        end
        if (exp.l) e_pkt++;
        in_pkt = !exp.l;
      end
    end
    if (clr) model_clear();
    if (s_axis_tvalid && s_axis_tready) begin
      q.push_back(cur);
      pending = 1'b0;
      n_in++;
    end
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    stats_clear = 1'b0;
    #1;
    q.delete();
    model_clear();
    in_pkt = 1'b0;
    pending = 1'b0;
    beats_left = 0;
    prev_sready = 1'b1;
    prev_mready = 1'b0;
    chk("rst_m_valid", m_axis_tvalid, 1'b0);
    chk("rst_s_ready", s_axis_tready, 1'b1);
    chk("rst_m_payload", {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast}, '0);
    chk_counters("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    stats_clear = 1'b0;
    cur = '0;
    g_rand = 1'b0;
    do_reset();
    // single 2-beat 64-byte packet from port 0
    g_nb = 2; g_len = 16'd64; g_port = 8'h01;
    step(1, 1, 0);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    chk("t1_pkt", pkt_count, 1);
    chk("t1_byte", byte_count, 64);
    chk("t1_port0", port_pkt_count[CW-1:0], 1);
    chk("t1_port_others", port_pkt_count[4*CW-1:CW], 0);
    // 100 back-to-back single-beat packets alternating ports 1 and 2
    step(0, 1, 1);
    g_nb = 1;
    for (int i = 0; i < 100; i++) begin
      g_port = (i % 2) ? 8'h10 : 8'h04;
      g_len = 16'($urandom_range(60, 1500));
      step(1, 1, 0);
      if (i > 0) chk("no_bubble", m_axis_tvalid, 1'b1);
    end
    repeat (3) step(0, 1, 0);
    chk("t2_pkt", pkt_count, 100);
    chk("t2_port1", port_pkt_count[CW +: CW], 50);
    chk("t2_port2", port_pkt_count[2*CW +: CW], 50);
    // random stream with random backpressure and occasional clears
    g_rand = 1'b1;
    n_in = 0;
    for (int c = 0; c < 6000 && n_in < 1000; c++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    chk("random_accept_budget", n_in >= 1000, 1'b1);
    for (int c = 0; c < 40 && (beats_left != 0 || pending); c++) step(1, 1, 0);
    for (int c = 0; c < 10 && q.size() != 0; c++) step(0, 1, 0);
    chk("drain_empty", q.size(), 0);
    step(0, 1, 0);
    g_rand = 1'b0;
    // byte counter wrap from a preset value
    @(negedge clk);
    force dut.byte_count = 32'hFFFF_FFF8;
    e_byte = 32'hFFFF_FFF8;
    @(posedge clk);
    @(negedge clk);
    release dut.byte_count;
    #1;
    g_nb = 1; g_len = 16'd10; g_port = 8'h40;
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    chk("wrap_byte", byte_count, 32'h2);
    // clear coinciding with the output tlast beat
    step(1, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    chk("clr_pkt", pkt_count, 0);
    chk("clr_byte", byte_count, 0);
    chk("clr_ports", port_pkt_count, 0);
    // reset after beat 2 of a 4-beat packet
    g_nb = 4; g_len = 16'd200; g_port = 8'h01;
    step(1, 1, 0);
    step(1, 1, 0);
    do_reset();
    g_nb = 1; g_len = 16'd77; g_port = 8'h04;
    step(1, 1, 0);
    repeat (2) step(0, 1, 0);
    chk("post_rst_pkt", pkt_count, 1);
    chk("post_rst_byte", byte_count, 77);
    chk("post_rst_port1", port_pkt_count[CW +: CW], 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nf10_filter_egress_stats.md
# nf10_filter_egress_stats

AXI4-Stream pass-through stage placed directly downstream of `nf10_filter`, between the filter's master stream and the output-port-lookup stage. It adds one register-slice boundary (full-throughput skid buffer) and maintains packet, byte and per-source-port counters for traffic that survived filtering. Counters are exposed as read-only register words for the AXI-Lite register block and are cleared by a single-cycle pulse from a write-only register.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width; [15:0] = packet length in bytes, [23:16] = one-hot source port.
- C_CNT_WIDTH, 32, width of every counter.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_aresetn  in  1  reset, asynchronous and active-low.
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  per parameters  upstream stream from nf10_filter.
- s_axis_tready  out  1  upstream backpressure.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  per parameters  downstream stream.
- m_axis_tready  in  1  downstream backpressure.
- stats_clear  in  1  synchronous one-cycle clear pulse.
- pkt_count  out  C_CNT_WIDTH  packets forwarded.
- byte_count  out  C_CNT_WIDTH  sum of tuser[15:0] of forwarded packets.
- port_pkt_count  out  4*C_CNT_WIDTH  packets per MAC port; slice i counts tuser bit 16+2*i (i=0..3).

## Operation
- Datapath: two-entry skid buffer (main register + skid register). Beats, including tdata, tstrb, tuser and tlast, pass unmodified and in order. There is no drop, reorder or insertion.
- s_axis_tready = NOT skid_valid, driven from a register with no combinational path from m_axis_tready.
- Input accept = s_axis_tvalid & s_axis_tready:
  - If the main register is empty, or is draining this cycle, the beat loads main.
  - Otherwise the beat loads skid.
- When main drains and skid is valid, skid moves to main.
- Counting is done at the output handshake (m_axis_tvalid & m_axis_tready), so counters reflect what downstream has actually taken.
- Framing FSM with states SOP and MID. Reset state is SOP.
  - SOP, beat accepted, tlast=0: go to MID.
  - SOP, beat accepted, tlast=1: stay in SOP (single-beat packet).
  - MID, beat accepted, tlast=1: go to SOP.
  - Any other case: hold state.
- Events on an accepted output beat:
  - Accepted beat in SOP: byte_count += tuser[15:0], zero-extended. For each i with tuser[16+2*i]=1, port_pkt_count[i] += 1. More than one set bit increments each corresponding counter.
  - Accepted beat with tlast=1: pkt_count += 1. A single-beat packet triggers both the SOP event and the tlast event on the same beat.
- All counters wrap modulo 2^C_CNT_WIDTH. There is no saturation.
- stats_clear = 1: all counters become 0 on the next edge. Clear has priority, so any count event in the same cycle is discarded. The framing FSM and the datapath are unaffected by clear.

## Timing
- Reset values (asynchronous, while axi_aresetn=0):
  - m_axis_tvalid=0, main valid=0, skid valid=0.
  - s_axis_tready=1.
  - FSM=SOP.
  - All counters=0.
  - m_axis_tdata/tstrb/tuser/tlast=0.
- Reset asserted mid-packet: the in-flight beats are discarded and the FSM returns to SOP. The first beat after reset is treated as a SOP.
- Latency: 1 cycle from input accept to m_axis_tvalid when the output is idle.
- Throughput: 1 beat per cycle sustained while m_axis_tready=1.
- Backpressure:
  - When m_axis_tready falls, at most one further beat is absorbed (into skid).
  - s_axis_tready deasserts the cycle after skid fills.
  - s_axis_tready reasserts the cycle after skid empties.
- m_axis_tvalid, once high, stays high with stable payload until accepted (AXI-Stream rule).
- Counter outputs are registered. Each updates 1 cycle after the output handshake that caused it.

## Test plan
- Single 64-byte packet, 2 beats, tuser[15:0]=64, tuser[23:16]=0x01, m_axis_tready=1:
  - Output beats match input 1 cycle later.
  - Final counts: pkt_count=1, byte_count=64, port_pkt_count[0]=1, all other ports 0.
- Back-to-back stream of 100 single-beat packets with alternating src ports 0x04 and 0x10:
  - No bubbles at the output.
  - pkt_count=100, port1=50, port2=50.
- Random m_axis_tready (50% duty) under a 1000-beat random stream:
  - Output sequence identical to input.
  - s_axis_tready never low for two consecutive cycles while the output drains every cycle.
  - No beat lost or duplicated.
- byte_count preset near wrap, via 65537 packets of 65535 bytes or via a force, then a 10-byte packet: byte_count wraps to the expected value modulo 2^32.
- stats_clear asserted on the same cycle as an output tlast beat: all counters read 0 the next cycle and that packet is not counted.
- axi_aresetn pulsed low mid-packet, after beat 2 of 4:
  - Immediately: m_axis_tvalid=0 and all counters=0.
  - A new 1-beat packet afterwards counts as SOP: pkt_count=1 and byte_count=its length.
